jesd204b_dl_tx_ctrl: RTL and testbench

- Transmit-side JESD204B data-link-layer controller for one lane, 4 octets per clock.
- Sequences the lane through Code Group Sync (CGS), Initial Lane Alignment Sequence (ILAS) and user DATA, driven by SYNC~ and the LMFC pulse.
- Applies non-scrambled end-of-frame/end-of-multiframe character replacement using the eof/eom octet flags from the frame-marking block.
- Sits between the transport layer and the 8b/10b encoder.

---
 rtl/jesd204b_dl_pkg.sv | 26 ++
 rtl/jesd204b_dl_char_replace.sv | 55 +++++
 rtl/jesd204b_dl_tx_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_jesd204b_dl_tx_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd204b_dl_pkg.sv
// Shared constants and types for the JESD204B transmit data-link controller.
package jesd204b_dl_pkg;

  localparam int unsigned OCT_W           = 8;
  localparam int unsigned OCTETS_PER_WORD = 4;
  localparam int unsigned WORD_W          = OCT_W * OCTETS_PER_WORD;

  // ILAS configuration octets occupy n = 2..15 of the second multiframe
  localparam int unsigned CFG_FIRST_OCTET = 2;
  localparam int unsigned CFG_NUM_OCTETS  = 14;
  localparam int unsigned CFG_W           = OCT_W * CFG_NUM_OCTETS;

  // Control characters
  localparam logic [OCT_W-1:0] K28_0 = 8'h1C;
  localparam logic [OCT_W-1:0] K28_3 = 8'h7C;
  localparam logic [OCT_W-1:0] K28_4 = 8'h9C;
  localparam logic [OCT_W-1:0] K28_5 = 8'hBC;
  localparam logic [OCT_W-1:0] K28_7 = 8'hFC;

  typedef enum logic [1:0] {
    CGS  = 2'd0,
    ILAS = 2'd1,
    DATA = 2'd2
  } dl_state_e;

endpackage

// File: rtl/jesd204b_dl_char_replace.sv
// Per-word end-of-frame / end-of-multiframe character replacement (non-scrambled).
module jesd204b_dl_char_replace
  import jesd204b_dl_pkg::*;
(
  input  logic [WORD_W-1:0]          tx_data,
  input  logic [OCTETS_PER_WORD-1:0] eof,
  input  logic [OCTETS_PER_WORD-1:0] eom,
  input  logic [OCT_W-1:0]           prev_oct,
  input  logic                       prev_valid,
  output logic [WORD_W-1:0]          data_c,
  output logic [OCTETS_PER_WORD-1:0] charisk_c,
  output logic [OCT_W-1:0]           prev_oct_c,
  output logic                       prev_valid_c
);

  logic [WORD_W-1:0]          data_s;
  logic [OCTETS_PER_WORD-1:0] eof_s;
  logic [OCTETS_PER_WORD-1:0] eom_s;
  logic [OCT_W-1:0]           oct;
  logic [OCT_W-1:0]           rep;
  logic                       isk;

  // Walk octets low to high so a frame end earlier in the word feeds later compares
  always_comb begin
    data_s       = tx_data;
    eof_s        = eof;
    eom_s        = eom;
    data_c       = '0;
    charisk_c    = '0;
    prev_oct_c   = prev_oct;
    prev_valid_c = prev_valid;
    oct          = '0;
    rep          = '0;
    isk          = 1'b0;
    for (int unsigned i = 0; i < OCTETS_PER_WORD; i++) begin
      oct = data_s[OCT_W-1:0];
      rep = oct;
      isk = 1'b0;
      if (eof_s[0]) begin
        if (prev_valid_c && (oct == prev_oct_c)) begin
          rep = eom_s[0] ? K28_3 : K28_7;
          isk = 1'b1;
        end
        prev_oct_c   = oct;
        prev_valid_c = 1'b1;
      end
      data_c    = {rep, data_c[WORD_W-1:OCT_W]};
      charisk_c = {isk, charisk_c[OCTETS_PER_WORD-1:1]};
      data_s    = data_s >> OCT_W;
      eof_s     = eof_s >> 1;
      eom_s     = eom_s >> 1;
    end
  end

endmodule

// File: rtl/jesd204b_dl_tx_ctrl.sv
// JESD204B TX data-link controller for one lane: CGS -> ILAS -> DATA sequencing.
module jesd204b_dl_tx_ctrl
  import jesd204b_dl_pkg::*;
#(
  parameter int unsigned OCTET_PER_SENT = 4,
  parameter int unsigned OCTETS_PER_FR  = 2,
  parameter int unsigned FRAMES_PER_MF  = 16,
  parameter int unsigned ILAS_MF        = 4,
  parameter int unsigned SYNC_LOW_CYC   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sync_n,
  input  logic                       lmfc,
  input  logic [WORD_W-1:0]          tx_data,
  input  logic [OCTETS_PER_WORD-1:0] eof,
  input  logic [OCTETS_PER_WORD-1:0] eom,
  input  logic [CFG_W-1:0]           cfg_octets,
  output logic [WORD_W-1:0]          tx_out,
  output logic [OCTETS_PER_WORD-1:0] tx_charisk,
  output logic                       tx_ready,
  output logic                       link_up,
  output logic                       sync_err
);

  localparam int unsigned OCT_PER_MF   = OCTETS_PER_FR * FRAMES_PER_MF;
  localparam int unsigned WORDS_PER_MF = OCT_PER_MF / OCTET_PER_SENT;
  localparam int unsigned WCNT_W       = (WORDS_PER_MF > 1) ? $clog2(WORDS_PER_MF) : 1;
  localparam int unsigned MFCNT_W      = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam int unsigned LOWCNT_W     = $clog2(SYNC_LOW_CYC + 1);

  dl_state_e                  state_q, state_d;
  logic [WCNT_W-1:0]          wcnt_q, wcnt_d;
  logic [MFCNT_W-1:0]         mfcnt_q, mfcnt_d;
  logic [LOWCNT_W-1:0]        lowcnt_q, lowcnt_d;
  logic [OCT_W-1:0]           prev_q, prev_d;
  logic                       pvalid_q, pvalid_d;
  logic [WORD_W-1:0]          tx_out_q, tx_out_d;
  logic [OCTETS_PER_WORD-1:0] charisk_q, charisk_d;
  logic                       ready_q, ready_d;
  logic                       link_q, link_d;
  logic                       err_q, err_d;

  logic [WORD_W-1:0]          rep_data;
  logic [OCTETS_PER_WORD-1:0] rep_k;
  logic [OCT_W-1:0]           rep_prev;
  logic                       rep_valid;

  logic [WORD_W-1:0]          ilas_word;
  logic [OCTETS_PER_WORD-1:0] ilas_k;
  logic [OCT_W-1:0]           ilas_oct;
  logic                       ilas_isk;
  int unsigned                octn;

  logic                       last_word;
  logic                       last_mf;
  logic                       resync;
  logic                       short_low;

  jesd204b_dl_char_replace u_char_replace (
    .tx_data      (tx_data),
    .eof          (eof),
    .eom          (eom),
    .prev_oct     (prev_q),
    .prev_valid   (pvalid_q),
    .data_c       (rep_data),
    .charisk_c    (rep_k),
    .prev_oct_c   (rep_prev),
    .prev_valid_c (rep_valid)
  );

  // ILAS word for the current position within the multiframe
  always_comb begin
    ilas_word = '0;
    ilas_k    = '0;
    ilas_oct  = '0;
    ilas_isk  = 1'b0;
    octn      = OCTET_PER_SENT * 32'(wcnt_q);
    for (int unsigned i = 0; i < OCTETS_PER_WORD; i++) begin
      ilas_oct = 8'(octn);
      ilas_isk = 1'b0;
      if (octn == 32'd0) begin
        ilas_oct = K28_0;
        ilas_isk = 1'b1;
      end else if (octn == OCT_PER_MF - 1) begin
        ilas_oct = K28_3;
        ilas_isk = 1'b1;
      end else if (mfcnt_q == MFCNT_W'(1)) begin
        if (octn == 32'd1) begin
          ilas_oct = K28_4;
          ilas_isk = 1'b1;
        end else if ((octn >= CFG_FIRST_OCTET) && (octn < CFG_FIRST_OCTET + CFG_NUM_OCTETS)) begin
          ilas_oct = 8'(cfg_octets >> (OCT_W * (octn - CFG_FIRST_OCTET)));
        end
      end
      ilas_word = {ilas_oct, ilas_word[WORD_W-1:OCT_W]};
      ilas_k    = {ilas_isk, ilas_k[OCTETS_PER_WORD-1:1]};
      octn      = octn + 32'd1;
    end
  end

  assign last_word = (wcnt_q == WCNT_W'(WORDS_PER_MF - 1));
  assign last_mf   = (mfcnt_q == MFCNT_W'(ILAS_MF - 1));
  assign resync    = !sync_n && ((32'(lowcnt_q) + 32'd1) >= SYNC_LOW_CYC);
  assign short_low = sync_n && (lowcnt_q != '0);

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    wcnt_d    = '0;
    mfcnt_d   = '0;
    lowcnt_d  = lowcnt_q;
    prev_d    = prev_q;
    pvalid_d  = 1'b0;
    tx_out_d  = {OCTETS_PER_WORD{K28_5}};
    charisk_d = '1;
    err_d     = 1'b0;

    if (sync_n) begin
      lowcnt_d = '0;
    end else if (lowcnt_q < LOWCNT_W'(SYNC_LOW_CYC)) begin
      lowcnt_d = lowcnt_q + LOWCNT_W'(1);
    end

    unique case (state_q)
      CGS: begin
        if (sync_n && lmfc) state_d = ILAS;
      end
      ILAS: begin
        tx_out_d  = ilas_word;
        charisk_d = ilas_k;
        wcnt_d    = last_word ? '0 : wcnt_q + WCNT_W'(1);
        mfcnt_d   = last_word ? mfcnt_q + MFCNT_W'(1) : mfcnt_q;
        err_d     = short_low;
        if (last_word && last_mf) state_d = DATA;
        if (resync) state_d = CGS;
      end
      DATA: begin
        tx_out_d  = rep_data;
        charisk_d = rep_k;
        prev_d    = rep_prev;
        pvalid_d  = rep_valid;
        err_d     = short_low;
        if (resync) state_d = CGS;
      end
      default: state_d = CGS;
    endcase

    // Counters only run inside ILAS; prev-valid only survives within DATA
    if (state_d != ILAS) begin
      wcnt_d  = '0;
      mfcnt_d = '0;
    end
    if ((state_q != DATA) || (state_d != DATA)) pvalid_d = 1'b0;

    ready_d = (state_d == DATA);
    link_d  = (state_d == DATA);
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CGS;
      wcnt_q    <= '0;
      mfcnt_q   <= '0;
      lowcnt_q  <= '0;
      prev_q    <= '0;
      pvalid_q  <= 1'b0;
      tx_out_q  <= {OCTETS_PER_WORD{K28_5}};
      charisk_q <= '1;
      ready_q   <= 1'b0;
      link_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mfcnt_q   <= mfcnt_d;
      lowcnt_q  <= lowcnt_d;
      prev_q    <= prev_d;
      pvalid_q  <= pvalid_d;
      tx_out_q  <= tx_out_d;
      charisk_q <= charisk_d;
      ready_q   <= ready_d;
      link_q    <= link_d;
      err_q     <= err_d;
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_charisk = charisk_q;
  assign tx_ready   = ready_q;
  assign link_up    = link_q;
  assign sync_err   = err_q;

endmodule

// File: tb/tb_jesd204b_dl_tx_ctrl.sv
// Scoreboard bench for the JESD204B TX data-link controller (default parameters).
module tb_jesd204b_dl_tx_ctrl;

  localparam int F       = 2;
  localparam int K       = 16;
  localparam int N_ILAS  = 4;
  localparam int LOW_LIM = 4;
  localparam int OCT_MF  = F * K;
  localparam int WORDS   = OCT_MF / 4;
  localparam int S_CGS   = 0;
  localparam int S_ILAS  = 1;
  localparam int S_DATA  = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         sync_n;
  logic         lmfc;
  logic [31:0]  tx_data;
  logic [3:0]   eof;
  logic [3:0]   eom;
  logic [111:0] cfg_octets;
  logic [31:0]  tx_out;
  logic [3:0]   tx_charisk;
  logic         tx_ready;
  logic         link_up;
  logic         sync_err;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  k;
    logic        ready;
    logic        link;
    logic        err;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] cfg_tab [14];
  int         n_checks = 0;
  int         n_pass   = 0;

  jesd204b_dl_tx_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .sync_n     (sync_n),
    .lmfc       (lmfc),
    .tx_data    (tx_data),
    .eof        (eof),
    .eom        (eom),
    .cfg_octets (cfg_octets),
    .tx_out     (tx_out),
    .tx_charisk (tx_charisk),
    .tx_ready   (tx_ready),
    .link_up    (link_up),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // {isk, octet} of ILAS octet n in multiframe mf
  function automatic logic [8:0] ilas_oct(input int mf, input int n);
    if (n == 0) return {1'b1, 8'h1C};
    if (n == OCT_MF - 1) return {1'b1, 8'h7C};
    if (mf == 1 && n == 1) return {1'b1, 8'h9C};
    if (mf == 1 && n >= 2 && n <= 15) return {1'b0, cfg_tab[n-2]};
    return {1'b0, 8'(n)};
  endfunction

  // Reference model: one expected output word per clock, compared a cycle later
  int         m_state;
  int         m_widx;
  int         m_low;
  logic [7:0] m_prev;
  logic       m_pvalid;

  always @(posedge clk) begin : model
    exp_t       e;
    int         nxt;
    int         g;
    logic [8:0] ko;
    logic [7:0] b;
    logic [7:0] r;
    logic       rk;
    logic [3:0] ef;
    logic [3:0] em;
    if (!reset) begin
      m_state  = S_CGS;
      m_widx   = 0;
      m_low    = 0;
      m_prev   = 8'h00;
      m_pvalid = 1'b0;
    end else begin
      e   = '0;
      nxt = m_state;
      if (m_state == S_CGS) begin
        e.data = 32'hBCBCBCBC;
        e.k    = 4'hF;
        m_low  = 0;
        if (sync_n && lmfc) begin
          nxt    = S_ILAS;
          m_widx = 0;
        end
      end else begin
        if (m_state == S_ILAS) begin
          for (int o = 0; o < 4; o++) begin
            g      = m_widx * 4 + o;
            ko     = ilas_oct(g / OCT_MF, g % OCT_MF);
            e.data = {ko[7:0], e.data[31:8]};
            e.k    = {ko[8], e.k[3:1]};
          end
          if (m_widx == N_ILAS * WORDS - 1) nxt = S_DATA;
          m_widx++;
        end else begin
          for (int o = 0; o < 4; o++) begin
            b  = 8'(tx_data >> (8 * o));
            ef = eof >> o;
            em = eom >> o;
            r  = b;
            rk = 1'b0;
            if (ef[0]) begin
              if (m_pvalid && b == m_prev) begin
                r  = em[0] ? 8'h7C : 8'hFC;
                rk = 1'b1;
              end
              m_prev   = b;
              m_pvalid = 1'b1;
            end
            e.data = {r, e.data[31:8]};
            e.k    = {rk, e.k[3:1]};
          end
        end
        if (!sync_n) begin
          m_low++;
          if (m_low >= LOW_LIM) nxt = S_CGS;
        end else begin
          if (m_low > 0) e.err = 1'b1;
          m_low = 0;
        end
      end
      if (nxt != S_DATA) m_pvalid = 1'b0;
      e.ready = (nxt == S_DATA);
      e.link  = (nxt == S_DATA);
      m_state = nxt;
      sb_q.push_back(e);
    end
  end

  // Compare DUT outputs against the oldest expected entry on the falling edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("sb_tx_out", tx_out, e.data);
      check_val("sb_charisk", 32'(tx_charisk), 32'(e.k));
      check_val("sb_tx_ready", 32'(tx_ready), 32'(e.ready));
      check_val("sb_link_up", 32'(link_up), 32'(e.link));
      check_val("sb_sync_err", 32'(sync_err), 32'(e.err));
    end
  end

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_tx_out"}, tx_out, 32'hBCBCBCBC);
    check_val({tag, "_charisk"}, 32'(tx_charisk), 32'hF);
    check_val({tag, "_tx_ready"}, 32'(tx_ready), 32'h0);
    check_val({tag, "_link_up"}, 32'(link_up), 32'h0);
    check_val({tag, "_sync_err"}, 32'(sync_err), 32'h0);
  endtask

  initial begin : stim
    int words;
    int budget;
    for (int i = 0; i < 14; i++) cfg_tab[i] = 8'(i);
    cfg_octets = 112'h0D0C0B0A09080706050403020100;
    reset   = 1'b0;
    sync_n  = 1'b0;
    lmfc    = 1'b0;
    tx_data = 32'h0;
    eof     = 4'h0;
    eom     = 4'h0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;

    // CGS hold: sync_n low, lmfc pulses must be ignored
    for (int c = 0; c < 20; c++) begin
      lmfc = (c % 8 == 7);
      @(negedge clk);
    end
    lmfc = 1'b0;
    sync_n = 1'b1;
    repeat (3) @(negedge clk);

    // CGS -> ILAS on lmfc
    lmfc = 1'b1;
    @(negedge clk);
    lmfc = 1'b0;
    @(negedge clk);
    check_val("ilas_w0", tx_out, 32'h0302011C);
    check_val("ilas_w0_k", 32'(tx_charisk), 32'h1);
    repeat (7) @(negedge clk);
    check_val("ilas_w7", tx_out, 32'h7C1E1D1C);
    check_val("ilas_w7_k", 32'(tx_charisk), 32'h8);
    @(negedge clk);
    check_val("ilas_mf1_w0", tx_out, 32'h01009C1C);
    check_val("ilas_mf1_w0_k", 32'(tx_charisk), 32'h3);
    words  = 9;
    budget = 100;
    while (!link_up && budget > 0) begin
      @(negedge clk);
      words++;
      budget--;
    end
    check_val("link_up_reached", 32'(link_up), 32'h1);
    check_val("ilas_word_count", 32'(words), 32'd32);
    check_val("ilas_last_word", tx_out, 32'h7C1E1D1C);

    // Character replacement on the first DATA words
    tx_data = 32'h55AA55AA;
    eof     = 4'b1010;
    eom     = 4'b0000;
    @(negedge clk);
    check_val("data_w0", tx_out, 32'hFCAA55AA);
    check_val("data_w0_k", 32'(tx_charisk), 32'h8);
    @(negedge clk);
    check_val("data_w1", tx_out, 32'hFCAAFCAA);
    check_val("data_w1_k", 32'(tx_charisk), 32'hA);
    eom = 4'b1000;
    @(negedge clk);
    check_val("data_eom", tx_out, 32'h7CAAFCAA);
    check_val("data_eom_k", 32'(tx_charisk), 32'hA);
    tx_data = 32'h04030201;
    eom     = 4'b0000;
    @(negedge clk);
    check_val("data_nomatch0", tx_out, 32'h04030201);
    check_val("data_nomatch0_k", 32'(tx_charisk), 32'h0);
    tx_data = 32'h08070605;
    @(negedge clk);
    check_val("data_nomatch1", tx_out, 32'h08070605);
    check_val("data_nomatch1_k", 32'(tx_charisk), 32'h0);

    // Random traffic from a small alphabet so frame ends repeat often
    for (int c = 0; c < 40; c++) begin
      for (int o = 0; o < 4; o++) begin
        case ($urandom_range(0, 2))
          0:       tx_data = {8'hAA, tx_data[31:8]};
          1:       tx_data = {8'h55, tx_data[31:8]};
          default: tx_data = {8'h33, tx_data[31:8]};
        endcase
      end
      eom  = ($urandom_range(0, 3) == 0) ? 4'b1000 : 4'b0000;
      lmfc = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    lmfc = 1'b0;

    // Short sync_n low: error pulse, link stays up
    sync_n = 1'b0;
    repeat (2) @(negedge clk);
    sync_n = 1'b1;
    @(negedge clk);
    check_val("short_low_err", 32'(sync_err), 32'h1);
    check_val("short_low_link", 32'(link_up), 32'h1);
    @(negedge clk);
    check_val("short_low_err_end", 32'(sync_err), 32'h0);

    // Long sync_n low: back to CGS
    sync_n = 1'b0;
    repeat (5) @(negedge clk);
    check_val("resync_tx_out", tx_out, 32'hBCBCBCBC);
    check_val("resync_ready", 32'(tx_ready), 32'h0);
    check_val("resync_link", 32'(link_up), 32'h0);
    repeat (3) @(negedge clk);

    // Re-enter ILAS, then reset in the middle of it
    sync_n = 1'b1;
    lmfc   = 1'b1;
    @(negedge clk);
    lmfc = 1'b0;
    repeat (12) @(negedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_reset_vals("mid_ilas_rst");
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_val("post_rst_cgs", tx_out, 32'hBCBCBCBC);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
